// File: rtl/keyboard_key_decoder_if.sv
// Byte stream from the PS/2 receiver in, level-held key outputs and error pulse out.
interface keyboard_key_decoder_if;
    logic [7:0] ps2_data;
    logic       ps2_valid;
    logic       key_space;
    logic       key_left;
    logic       key_right;
    logic       kbd_err;

    modport master (
        output ps2_data,
        output ps2_valid,
        input  key_space,
        input  key_left,
        input  key_right,
        input  kbd_err
    );

    modport slave (
        input  ps2_data,
        input  ps2_valid,
        output key_space,
        output key_left,
        output key_right,
        output kbd_err
    );
endinterface

// File: rtl/keyboard_key_decoder.sv
// Scan-code set 2 decoder: tracks make/break/E0 sequences and holds space, left and right key levels.
//
// state   | meaning
// IDLE    | waiting for a make code or a prefix byte
// EXT     | E0 received, next byte is an extended code
// BRK     | F0 received, next byte is the released key
// EXT_BRK | E0 F0 received, next byte is the released extended key
module keyboard_key_decoder #(
    parameter int unsigned CLK_FREQ       = 65_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 1_300_000
) (
    input  logic                  clk,
    input  logic                  rst,
    keyboard_key_decoder_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    localparam logic [7:0] C_EXT   = 8'hE0;
    localparam logic [7:0] C_BRK   = 8'hF0;
    localparam logic [7:0] C_SPACE = 8'h29;
    localparam logic [7:0] C_A     = 8'h1C;
    localparam logic [7:0] C_D     = 8'h23;
    localparam logic [7:0] C_LEFT  = 8'h6B;
    localparam logic [7:0] C_RIGHT = 8'h74;
    localparam logic [7:0] C_OVR0  = 8'h00;
    localparam logic [7:0] C_OVR1  = 8'hFF;

    localparam logic [20:0] TO_LAST = 21'(TIMEOUT_CYCLES - 1);
    localparam logic [20:0] CNT_MAX = '1;

    if (CLK_FREQ == 0) begin : g_bad_clk
        $error("keyboard_key_decoder: CLK_FREQ must be non-zero");
    end
    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 2097152) begin : g_bad_timeout
        $error("keyboard_key_decoder: TIMEOUT_CYCLES must fit the 21-bit counter");
    end

    state_t      state, state_n;
    logic [20:0] cnt, cnt_n;
    logic        sp_h, a_h, d_h, la_h, ra_h;
    logic        sp_n, a_n, d_n, la_n, ra_n;
    logic        err_n;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sp_n    = sp_h;
        a_n     = a_h;
        d_n     = d_h;
        la_n    = la_h;
        ra_n    = ra_h;
        err_n   = 1'b0;

        if (bus.ps2_valid) begin
            cnt_n = '0;
            case (state)
                IDLE: begin
                    case (bus.ps2_data)
                        C_EXT:   state_n = EXT;
                        C_BRK:   state_n = BRK;
                        C_SPACE: sp_n = 1'b1;
                        C_A:     a_n  = 1'b1;
                        C_D:     d_n  = 1'b1;
                        C_OVR0, C_OVR1: begin
                            sp_n  = 1'b0;
                            a_n   = 1'b0;
                            d_n   = 1'b0;
                            la_n  = 1'b0;
                            ra_n  = 1'b0;
                            err_n = 1'b1;
                        end
                        default: ;
                    endcase
                end
                EXT: begin
                    case (bus.ps2_data)
                        C_BRK: state_n = EXT_BRK;
                        C_EXT: state_n = EXT;
                        C_LEFT: begin
                            la_n    = 1'b1;
                            state_n = IDLE;
                        end
                        C_RIGHT: begin
                            ra_n    = 1'b1;
                            state_n = IDLE;
                        end
                        default: state_n = IDLE;
                    endcase
                end
                BRK: begin
                    case (bus.ps2_data)
                        C_SPACE: sp_n = 1'b0;
                        C_A:     a_n  = 1'b0;
                        C_D:     d_n  = 1'b0;
                        default: ;
                    endcase
                    state_n = IDLE;
                end
                EXT_BRK: begin
                    case (bus.ps2_data)
                        C_LEFT:  la_n = 1'b0;
                        C_RIGHT: ra_n = 1'b0;
                        default: ;
                    endcase
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end else if (state != IDLE) begin
            // A stalled prefix is abandoned; held keys keep their levels.
            if (cnt == TO_LAST) begin
                state_n = IDLE;
                cnt_n   = '0;
                err_n   = 1'b1;
            end else if (cnt != CNT_MAX) begin
                cnt_n = cnt + 21'd1;
            end
        end else begin
            cnt_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            sp_h          <= 1'b0;
            a_h           <= 1'b0;
            d_h           <= 1'b0;
            la_h          <= 1'b0;
            ra_h          <= 1'b0;
            bus.key_space <= 1'b0;
            bus.key_left  <= 1'b0;
            bus.key_right <= 1'b0;
            bus.kbd_err   <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            sp_h          <= sp_n;
            a_h           <= a_n;
            d_h           <= d_n;
            la_h          <= la_n;
            ra_h          <= ra_n;
            bus.key_space <= sp_n;
            bus.key_left  <= a_n | la_n;
            bus.key_right <= d_n | ra_n;
            bus.kbd_err   <= err_n;
        end
    end
endmodule

// File: tb/tb_keyboard_key_decoder.sv
// Bench for keyboard_key_decoder: vector table, hand-written timeout/reset sequences, randomized run vs. reference model.
module tb_keyboard_key_decoder;
    localparam int T = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    keyboard_key_decoder_if bus ();

    keyboard_key_decoder #(
        .CLK_FREQ      (65_000_000),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: pending prefix bytes and a set of held physical keys.
    logic [7:0] pre[$];
    bit   [4:0] held;   // 0 space, 1 A, 2 D, 3 left arrow, 4 right arrow
    int         idle;
    bit         m_err;

    function automatic int key_idx(bit ext, logic [7:0] c);
        if (!ext) begin
            if (c == 8'h29) return 0;
            if (c == 8'h1C) return 1;
            if (c == 8'h23) return 2;
        end else begin
            if (c == 8'h6B) return 3;
            if (c == 8'h74) return 4;
        end
        return -1;
    endfunction

    task automatic model_step(input bit r, input bit v, input logic [7:0] d);
        int k;
        m_err = 1'b0;
        if (r) begin
            pre.delete();
            held = '0;
            idle = 0;
        end else if (v) begin
            idle = 0;
            if (pre.size() == 0) begin
                if (d == 8'hE0 || d == 8'hF0) pre.push_back(d);
                else if (d == 8'h00 || d == 8'hFF) begin
                    held  = '0;
                    m_err = 1'b1;
                end else begin
                    k = key_idx(1'b0, d);
                    if (k >= 0) held[k] = 1'b1;
                end
            end else if (pre[pre.size()-1] == 8'hF0) begin
                k = key_idx(pre[0] == 8'hE0, d);
                if (k >= 0) held[k] = 1'b0;
                pre.delete();
            end else begin
                if (d == 8'hF0) pre.push_back(d);
                else if (d != 8'hE0) begin
                    k = key_idx(1'b1, d);
                    if (k >= 0) held[k] = 1'b1;
                    pre.delete();
                end
            end
        end else if (pre.size() > 0) begin
            idle++;
            if (idle == T) begin
                pre.delete();
                idle  = 0;
                m_err = 1'b1;
            end
        end
    endtask

    function automatic logic [3:0] model_out();
        return {held[0], held[1] | held[3], held[2] | held[4], m_err};
    endfunction

    function automatic logic [3:0] dut_out();
        return {bus.key_space, bus.key_left, bus.key_right, bus.kbd_err};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual(sp,l,r,err)=%b expected=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [7:0] d);
        rst           = r;
        bus.ps2_valid = v;
        bus.ps2_data  = d;
        @(posedge clk);
        model_step(r, v, d);
        #1;
    endtask

    typedef struct {
        bit         r;
        bit         v;
        logic [7:0] d;
        logic [3:0] exp;   // {key_space, key_left, key_right, kbd_err}
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit r, bit v, logic [7:0] d, logic [3:0] e);
        vec_t x;
        x.r = r; x.v = v; x.d = d; x.exp = e;
        vecs.push_back(x);
    endfunction

    logic [7:0] mains[7];

    initial begin
        bus.ps2_valid = 1'b0;
        bus.ps2_data  = 8'h00;
        held = '0;
        idle = 0;
        mains[0] = 8'hE0; mains[1] = 8'hF0; mains[2] = 8'h29; mains[3] = 8'h1C;
        mains[4] = 8'h23; mains[5] = 8'h6B; mains[6] = 8'h74;

        add(1, 0, 8'h00, 4'b0000);
        add(0, 0, 8'h00, 4'b0000);
        // space make/break
        add(0, 1, 8'h29, 4'b1000);
        add(0, 0, 8'h00, 4'b1000);
        add(0, 1, 8'hF0, 4'b1000);
        add(0, 1, 8'h29, 4'b0000);
        // arrow left plus A, arrow break keeps left asserted
        add(0, 1, 8'hE0, 4'b0000);
        add(0, 1, 8'h6B, 4'b0100);
        add(0, 1, 8'h1C, 4'b0100);
        add(0, 1, 8'hE0, 4'b0100);
        add(0, 1, 8'hF0, 4'b0100);
        add(0, 1, 8'h6B, 4'b0100);
        add(0, 1, 8'hF0, 4'b0100);
        add(0, 1, 8'h1C, 4'b0000);
        // typematic right arrow, back to back
        for (int i = 0; i < 5; i++) begin
            add(0, 1, 8'hE0, i == 0 ? 4'b0000 : 4'b0010);
            add(0, 1, 8'h74, 4'b0010);
        end
        add(0, 1, 8'hE0, 4'b0010);
        add(0, 1, 8'hF0, 4'b0010);
        add(0, 1, 8'h74, 4'b0000);
        // overrun clears everything
        add(0, 1, 8'h29, 4'b1000);
        add(0, 1, 8'h1C, 4'b1100);
        add(0, 1, 8'h23, 4'b1110);
        add(0, 1, 8'hFF, 4'b0001);
        add(0, 0, 8'h00, 4'b0000);
        // left and right together, then 00 overrun
        add(0, 1, 8'h1C, 4'b0100);
        add(0, 1, 8'hE0, 4'b0100);
        add(0, 1, 8'h74, 4'b0110);
        add(0, 1, 8'h00, 4'b0001);
        // ignored codes and stray breaks
        add(0, 1, 8'hAA, 4'b0000);
        add(0, 1, 8'h6B, 4'b0000);
        add(0, 1, 8'hE0, 4'b0000);
        add(0, 1, 8'h1C, 4'b0000);
        // E0 after F0 is consumed as the break byte; the following 6B is ignored
        add(0, 1, 8'h23, 4'b0010);
        add(0, 1, 8'hF0, 4'b0010);
        add(0, 1, 8'hE0, 4'b0010);
        add(0, 1, 8'h6B, 4'b0010);
        add(0, 1, 8'hF0, 4'b0010);
        add(0, 1, 8'h23, 4'b0000);
        // reset mid-sequence
        add(0, 1, 8'h29, 4'b1000);
        add(0, 1, 8'hE0, 4'b1000);
        add(0, 1, 8'hF0, 4'b1000);
        add(1, 0, 8'h00, 4'b0000);
        add(0, 1, 8'h6B, 4'b0000);

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].v, vecs[i].d);
            check($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
        end

        // space held across a long gap
        step(0, 1, 8'h29);
        check("long_make", dut_out(), 4'b1000);
        for (int i = 0; i < 100; i++) step(0, 0, 8'h00);
        check("long_hold", dut_out(), 4'b1000);
        step(0, 1, 8'hF0);
        step(0, 1, 8'h29);
        check("long_break", dut_out(), 4'b0000);

        // timeout after E0, then 74 is ignored
        step(0, 1, 8'hE0);
        for (int i = 0; i < T - 1; i++) step(0, 0, 8'h00);
        check("to_before", dut_out(), 4'b0000);
        step(0, 0, 8'h00);
        check("to_pulse", dut_out(), 4'b0001);
        step(0, 0, 8'h00);
        check("to_after", dut_out(), 4'b0000);
        step(0, 1, 8'h74);
        check("to_74_ignored", dut_out(), 4'b0000);

        // byte arriving on the timeout cycle wins
        step(0, 1, 8'hE0);
        for (int i = 0; i < T - 1; i++) step(0, 0, 8'h00);
        step(0, 1, 8'h74);
        check("to_byte_wins", dut_out(), 4'b0010);
        step(0, 0, 8'h00);
        check("to_byte_wins_quiet", dut_out(), 4'b0010);

        // timeout inside BRK leaves held flags
        step(0, 1, 8'hF0);
        for (int i = 0; i < T; i++) step(0, 0, 8'h00);
        check("to_brk_keep", dut_out(), 4'b0011);
        step(0, 1, 8'h74);
        check("to_brk_ignored_break", dut_out(), 4'b0010);
        for (int i = 0; i < 2 * T; i++) step(0, 0, 8'h00);
        check("idle_no_timeout", dut_out(), 4'b0010);

        // randomized run against the model
        for (int n = 0; n < 2500; n++) begin
            int sel;
            sel = $urandom_range(0, 999);
            if (sel < 2) begin
                step(1, 0, 8'h00);
            end else if (sel < 12) begin
                int gap;
                gap = $urandom_range(T - 5, T + 10);
                for (int g = 0; g < gap; g++) begin
                    step(0, 0, 8'h00);
                    check("rand_gap", dut_out(), model_out());
                end
            end else if (sel < 450) begin
                step(0, 0, 8'h00);
            end else if (sel < 480) begin
                step(0, 1, 8'($urandom_range(0, 255)));
            end else if (sel < 485) begin
                step(0, 1, ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00);
            end else begin
                step(0, 1, mains[$urandom_range(0, 6)]);
            end
            check("rand", dut_out(), model_out());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/keyboard_key_decoder.md
# keyboard_key_decoder

Converts the byte stream from the PS/2 keyboard receiver (scan code set 2) into the three level-held key signals that drive the character controller: `key_space`, `key_left` and `key_right`. It tracks make, break and extended (E0) sequences per physical key, so a key stays asserted from its make code until its break code. Typematic repeats are absorbed without glitches. The block sits between the PS/2 receiver and the character controller, in the 65 MHz VGA clock domain.

## Interface
Parameters:
- CLK_FREQ, 65_000_000, system clock frequency in Hz (documentation/derivation only)
- TIMEOUT_CYCLES, 1_300_000, maximum idle cycles allowed inside a multi-byte sequence (20 ms at 65 MHz)

Ports:
- clk  in  1  system clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- ps2_data  in  8  received scan-code byte; valid only when ps2_valid=1
- ps2_valid  in  1  single-cycle strobe, one per byte; may be asserted on consecutive cycles
- key_space  out  1  space held
- key_left  out  1  left arrow OR 'A' held
- key_right  out  1  right arrow OR 'D' held
- kbd_err  out  1  one-cycle pulse on sequence timeout or receiver overrun code

## Operation
- Internal held flags, all registered: sp_h (space), a_h ('A'), d_h ('D'), la_h (E0 6B), ra_h (E0 74).
- Outputs are registered: key_space=sp_h, key_left=a_h|la_h, key_right=d_h|ra_h.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen). A byte is consumed only when ps2_valid=1.
- IDLE:
  - E0 -> EXT; F0 -> BRK.
  - 29 -> sp_h=1; 1C -> a_h=1; 23 -> d_h=1.
  - 00 or FF (overrun) -> clear all five flags and pulse kbd_err.
  - Any other byte (AA, FA, EE, E1, ...) is ignored; the FSM stays in IDLE.
- EXT:
  - F0 -> EXT_BRK; E0 -> stay in EXT.
  - 6B -> la_h=1, then IDLE; 74 -> ra_h=1, then IDLE.
  - Any other byte -> IDLE with no flag change.
- BRK: 29 -> sp_h=0; 1C -> a_h=0; 23 -> d_h=0. Any byte, including these, returns the FSM to IDLE.
- EXT_BRK: 6B -> la_h=0; 74 -> ra_h=0. Any byte returns the FSM to IDLE.
- Repeated make codes re-set a flag that is already 1, so the output does not change.
- Left and right may be asserted together. Arbitration belongs to the consumer, not to this block.
- Timeout:
  - A counter (21 bits, saturating) clears on every ps2_valid and counts while the FSM is not in IDLE.
  - When the count reaches TIMEOUT_CYCLES-1 with no valid byte, the FSM goes to IDLE, kbd_err pulses, and the flags are left unchanged.
  - The counter does not run while the FSM is in IDLE.
- The E1 (Pause) sequence needs no special handling: its bytes fall through as ignored codes, and the F0 14 / F0 77 pairs land in BRK and are discarded.

## Timing
- Reset values: state=IDLE, all flags=0, key_space=key_left=key_right=0, kbd_err=0, timeout counter=0.
- Latency: the outputs reflect a completing byte on the first clk edge after the byte's valid cycle. The byte is sampled at edge N and the outputs are updated at edge N+1.
- kbd_err lasts exactly one cycle and shares the same one-cycle register latency.
- Back-to-back valid bytes are each processed in sequence; none are dropped.
- If a timeout and ps2_valid occur in the same cycle, the byte wins: it is processed and no timeout fires.
- Asserting rst mid-sequence (for example after E0 F0) discards the partial sequence and clears all keys on the next edge.
- The block has no backpressure. Bytes arriving on ps2_valid are always accepted.

## Test plan
- Make 29, wait 100 cycles, then F0 29 -> key_space rises 1 cycle after the 29 strobe and falls 1 cycle after the final 29 strobe; key_left and key_right stay 0 throughout.
- E0 6B, then 1C, then E0 F0 6B -> key_left=1 after the 6B make and stays 1 after the arrow break because 'A' is still held; F0 1C then drives key_left=0.
- E0 74 repeated ×5 on consecutive cycles, then E0 F0 74 -> key_right is 1 with no glitch through the repeats and goes to 0 exactly once.
- E0, then no byte for TIMEOUT_CYCLES -> kbd_err pulses once, the FSM is back in IDLE, and a following 74 is ignored (key_right=0).
- Hold 29, 1C and 23, then send FF -> all three outputs go to 0 and kbd_err pulses one cycle after the FF strobe.
- Send E0 F0, assert rst for 1 cycle, then send 6B -> all outputs are 0 after reset, and the 6B is ignored in IDLE (key_left stays 0).
